// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the SDRAM command-port arbiter.
// Owner encoding doubles as the tag-FIFO destination bit.
package mem_port_arbiter_pkg;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;

  localparam logic PORT_VID = 1'b0;
  localparam logic PORT_USB = 1'b1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  typedef struct packed {
    logic             owner;
    logic [LEN_W-1:0] len;
  } tag_t;
endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// Small synchronous FIFO of outstanding read tags; head is visible combinationally.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module mem_port_arbiter_tag_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (video scan-out, USB) in front of the SDRAM controller command port.
// Read beats are steered back to their issuer in order via the tag FIFO.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TAG_DEPTH  = 4
) (
  input  logic              mem_clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [LEN_W-1:0]  vid_len,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              usb_req,
  input  logic              usb_we,
  input  logic [ADDR_W-1:0] usb_addr,
  input  logic [LEN_W-1:0]  usb_len,
  input  logic [DATA_W-1:0] usb_wdata,
  output logic              usb_ack,
  output logic              usb_rvalid,
  output logic [DATA_W-1:0] usb_rdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              err
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [0:0]        r_state;
  logic              r_owner;
  logic              r_cmd_valid;
  logic              r_cmd_we;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [LEN_W-1:0]  r_cmd_len;
  logic [DATA_W-1:0] r_cmd_wdata;
  logic [SW-1:0]     r_starve_cnt;
  logic [LEN_W-1:0]  r_beat_cnt;
  logic              r_err;
  logic              r_vid_rvalid;
  logic              r_usb_rvalid;
  logic [DATA_W-1:0] r_vid_rdata;
  logic [DATA_W-1:0] r_usb_rdata;

  tag_t w_head;
  tag_t w_push_tag;
  logic w_full, w_empty, w_accept, w_push, w_pop, w_beat;
  logic w_vid_elig, w_usb_elig, w_vid_win, w_usb_win;

  assign w_accept   = r_cmd_valid & cmd_ready;
  assign w_push     = w_accept & ~r_cmd_we;
  assign w_push_tag = {r_owner, r_cmd_len};
  assign w_beat     = rd_valid & ~w_empty;
  assign w_pop      = w_beat & (r_beat_cnt == w_head.len);

  // Eligibility sees the full flag before any pop in this cycle.
  assign w_vid_elig = vid_req & ~w_full;
  assign w_usb_elig = usb_req & (usb_we | ~w_full);
  assign w_usb_win  = (r_state == IDLE) & w_usb_elig &
                      (~w_vid_elig | (r_starve_cnt == SW'(STARVE_MAX)));
  assign w_vid_win  = (r_state == IDLE) & w_vid_elig & ~w_usb_win;

  mem_port_arbiter_tag_fifo #(
    .WIDTH ($bits(tag_t)),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (mem_clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_push_tag),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge mem_clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= PORT_VID;
      r_cmd_valid  <= 1'b0;
      r_cmd_we     <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_len    <= '0;
      r_cmd_wdata  <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (r_state == IDLE) begin
        if (w_usb_win) begin
          r_state     <= HOLD;
          r_cmd_valid <= 1'b1;
          r_owner     <= PORT_USB;
          r_cmd_we    <= usb_we;
          r_cmd_addr  <= usb_addr;
          r_cmd_len   <= usb_we ? '0 : usb_len;
          r_cmd_wdata <= usb_wdata;
        end else if (w_vid_win) begin
          r_state     <= HOLD;
          r_cmd_valid <= 1'b1;
          r_owner     <= PORT_VID;
          r_cmd_we    <= 1'b0;
          r_cmd_addr  <= vid_addr;
          r_cmd_len   <= vid_len;
          r_cmd_wdata <= '0;
        end
      end else if (w_accept) begin
        r_state     <= IDLE;
        r_cmd_valid <= 1'b0;
      end

      if (!usb_req || w_usb_win) begin
        r_starve_cnt <= '0;
      end else if (w_vid_win && (r_starve_cnt != SW'(STARVE_MAX))) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  // Return path: beats with no outstanding tag are dropped and flagged.
  always_ff @(posedge mem_clk) begin
    if (reset) begin
      r_beat_cnt   <= '0;
      r_err        <= 1'b0;
      r_vid_rvalid <= 1'b0;
      r_usb_rvalid <= 1'b0;
      r_vid_rdata  <= '0;
      r_usb_rdata  <= '0;
    end else begin
      r_vid_rvalid <= w_beat & (w_head.owner == PORT_VID);
      r_usb_rvalid <= w_beat & (w_head.owner == PORT_USB);
      if (w_beat && (w_head.owner == PORT_VID)) r_vid_rdata <= rd_data;
      if (w_beat && (w_head.owner == PORT_USB)) r_usb_rdata <= rd_data;
      if (w_beat) r_beat_cnt <= w_pop ? '0 : r_beat_cnt + 1'b1;
      if (rd_valid && w_empty) r_err <= 1'b1;
    end
  end

  assign vid_ack    = w_accept & (r_owner == PORT_VID);
  assign usb_ack    = w_accept & (r_owner == PORT_USB);
  assign cmd_valid  = r_cmd_valid;
  assign cmd_we     = r_cmd_we;
  assign cmd_addr   = r_cmd_addr;
  assign cmd_len    = r_cmd_len;
  assign cmd_wdata  = r_cmd_wdata;
  assign vid_rvalid = r_vid_rvalid;
  assign vid_rdata  = r_vid_rdata;
  assign usb_rvalid = r_usb_rvalid;
  assign usb_rdata  = r_usb_rdata;
  assign err        = r_err;
endmodule
